// File: rtl/mu0_datapath_stack.sv
// MU0 datapath (Acc/PC/IR, X/Y/address muxes, 4-op ALU) with a return-address stack for JSR/RTS.
// Optional build macro MU0_CARRY_FLAG_EN adds a registered ALU carry flag C; otherwise C is tied low.
module mu0_datapath_stack #(
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned ADDR_W      = 12,
   parameter int unsigned STACK_DEPTH = 4
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [DATA_W-1:0] Din,
   input  logic              X_sel,
   input  logic              Y_sel,
   input  logic              Addr_sel,
   input  logic              PC_En,
   input  logic              IR_En,
   input  logic              Acc_En,
   input  logic [1:0]        M,
   input  logic              Push,
   input  logic              Pop,
   output logic [3:0]        F,
   output logic [ADDR_W-1:0] Address,
   output logic [DATA_W-1:0] Dout,
   output logic              N,
   output logic              Z,
   output logic              C,
   output logic [ADDR_W-1:0] PC,
   output logic [DATA_W-1:0] Acc,
   output logic              Stk_Full,
   output logic              Stk_Empty,
   output logic              Stk_Err
);

   localparam int unsigned PTR_W = $clog2(STACK_DEPTH);
   localparam int unsigned OCC_W = PTR_W + 1;

   logic [DATA_W-1:0] ir;
   logic [DATA_W-1:0] x;
   logic [DATA_W-1:0] y;
   logic [DATA_W-1:0] alu;
   logic [OCC_W-1:0]  occ;
   logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
   logic [ADDR_W-1:0] stack_top;
   logic              push_ok;
   logic              pop_ok;
   logic              stk_err_evt;

   // Operand and address selection
   assign x       = X_sel    ? DATA_W'(PC)         : Acc;
   assign y       = Y_sel    ? ir                  : Din;
   assign Address = Addr_sel ? ir[ADDR_W-1:0]      : PC;
   assign Dout    = x;
   assign F       = ir[DATA_W-1:DATA_W-4];
   assign N       = Acc[DATA_W-1];
   assign Z       = (Acc == '0);

`ifdef MU0_CARRY_FLAG_EN
   logic [DATA_W:0] alu_ext;
   logic            carry_nxt;

   // Extended ALU; for subtraction the top bit is the borrow, so C is its inverse
   always_comb begin
      alu_ext   = {1'b0, y};
      carry_nxt = 1'b0;
      case (M)
         2'b00: begin
            alu_ext   = {1'b0, y};
            carry_nxt = 1'b0;
         end
         2'b01: begin
            alu_ext   = {1'b0, x} + {1'b0, y};
            carry_nxt = alu_ext[DATA_W];
         end
         2'b10: begin
            alu_ext   = {1'b0, x} + (DATA_W+1)'(1);
            carry_nxt = alu_ext[DATA_W];
         end
         default: begin
            alu_ext   = {1'b0, x} - {1'b0, y};
            carry_nxt = ~alu_ext[DATA_W];
         end
      endcase
   end

   assign alu = alu_ext[DATA_W-1:0];

   always_ff @(posedge Clk) begin
      if (Reset)       C <= 1'b0;
      else if (Acc_En) C <= carry_nxt;
   end
`else
   always_comb begin
      alu = y;
      case (M)
         2'b00:   alu = y;
         2'b01:   alu = x + y;
         2'b10:   alu = x + DATA_W'(1);
         default: alu = x - y;
      endcase
   end

   assign C = 1'b0;
`endif

   // Stack control: simultaneous push/pop, overflow and underflow are all no-ops that flag an error
   assign Stk_Full    = (occ == OCC_W'(STACK_DEPTH));
   assign Stk_Empty   = (occ == '0);
   assign push_ok     = Push & ~Pop & ~Stk_Full & ~Reset;
   assign pop_ok      = Pop & ~Push & ~Stk_Empty;
   assign stk_err_evt = (Push & Pop) | (Push & Stk_Full) | (Pop & Stk_Empty);
   assign stack_top   = stack_mem[PTR_W'(occ - OCC_W'(1))];

   always_ff @(posedge Clk) begin
      if (push_ok) stack_mem[occ[PTR_W-1:0]] <= PC;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         occ     <= '0;
         Stk_Err <= 1'b0;
      end else begin
         if (push_ok)     occ <= occ + OCC_W'(1);
         else if (pop_ok) occ <= occ - OCC_W'(1);
         if (stk_err_evt) Stk_Err <= 1'b1;
      end
   end

   // Architectural registers; a successful pop takes priority over PC_En
   always_ff @(posedge Clk) begin
      if (Reset) begin
         PC  <= '0;
         Acc <= '0;
         ir  <= '0;
      end else begin
         if (pop_ok)     PC <= stack_top;
         else if (PC_En) PC <= alu[ADDR_W-1:0];
         if (Acc_En)     Acc <= alu;
         if (IR_En)      ir  <= Din;
      end
   end

endmodule
